// File: rtl/bus_monitor_pkg.sv
// Shared types for the Z80 I/O bus monitor.
// Defining IO_CAPTURE_TIMESTAMP_EN adds a 16-bit cycle stamp to every recorded event.
package bus_monitor_pkg;
    localparam logic DIR_WR  = 1'b0;
    localparam logic DIR_RD  = 1'b1;
    localparam int   IO_TS_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic       dir;
        logic [7:0] addr;
        logic [7:0] data;
`ifdef IO_CAPTURE_TIMESTAMP_EN
        logic [IO_TS_W-1:0] tstamp;
`endif
    } io_event_t;
endpackage

// File: rtl/monitor_fifo.sv
// Show-ahead FIFO of io_event_t; the output holds the last popped entry while empty.
module monitor_fifo
    import bus_monitor_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_cpu,
    input  logic             reset_cpu,
    input  logic             wr_en,
    input  io_event_t        wr_data,
    input  logic             rd_en,
    output io_event_t        rd_data,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    io_event_t       mem [DEPTH];
    io_event_t       last_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            rd_ok;
    logic            wr_ok;

    assign empty   = (level == '0);
    assign full    = (level == CNT_W'(DEPTH));
    assign rd_ok   = rd_en & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk_cpu) begin
        if (reset_cpu) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            last_q <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            level <= level + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/io_cycle_capture.sv
// Records completed Z80 I/O reads/writes inside [ADR_LO, ADR_HI] into a show-ahead event stream.
// Optional IO_CAPTURE_TIMESTAMP_EN: stamps each event with a free-running 16-bit cycle count (ev_time).
//
// state     | meaning
// ST_IDLE   | no access armed for this direction
// ST_ACTIVE | strobe rose cleanly; event is emitted when it falls
module io_cycle_capture
    import bus_monitor_pkg::*;
#(
    parameter logic [7:0] ADR_LO = 8'h50,
    parameter logic [7:0] ADR_HI = 8'h52,
    parameter int         DEPTH  = 16,
    parameter int         CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk_cpu,
    input  logic               reset_cpu,
    input  logic [7:0]         a_cpu,
    input  logic [7:0]         d_cpu,
    input  logic               wr_cpu,
    input  logic               rd_cpu,
    input  logic               io_req_cpu,
    input  logic               capture_en,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic               ev_dir,
    output logic [7:0]         ev_addr,
    output logic [7:0]         ev_data,
`ifdef IO_CAPTURE_TIMESTAMP_EN
    output logic [IO_TS_W-1:0] ev_time,
`endif
    output logic [CNT_W-1:0]   ev_level,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    input  logic               ovf_clr
);
    logic       s_wstb, s_rstb, s_en;
    logic       p_wstb, p_rstb;
    logic [7:0] s_addr, s_data;
    logic [7:0] h_addr, h_data;
    acc_state_t wr_st, rd_st;

    logic       wr_end, rd_end, in_win, push, pop, drop;
    logic       fifo_full, fifo_empty;
    io_event_t  ev_in, ev_head;

    // Strobe registers reset to 1 so an access already in progress at reset release never arms.
    always_ff @(posedge clk_cpu) begin
        if (reset_cpu) begin
            s_wstb <= 1'b1;
            s_rstb <= 1'b1;
            p_wstb <= 1'b1;
            p_rstb <= 1'b1;
            s_en   <= 1'b0;
            s_addr <= '0;
            s_data <= '0;
            h_addr <= '0;
            h_data <= '0;
            wr_st  <= ST_IDLE;
            rd_st  <= ST_IDLE;
        end else begin
            s_wstb <= ~(io_req_cpu | wr_cpu);
            s_rstb <= ~(io_req_cpu | rd_cpu);
            s_en   <= capture_en;
            s_addr <= a_cpu;
            s_data <= d_cpu;
            p_wstb <= s_wstb;
            p_rstb <= s_rstb;
            if (s_wstb | s_rstb) begin
                h_addr <= s_addr;
                h_data <= s_data;
            end
            if (s_wstb & s_rstb) begin
                wr_st <= ST_IDLE;
                rd_st <= ST_IDLE;
            end else begin
                case (wr_st)
                    ST_IDLE:   if (s_wstb & ~p_wstb) wr_st <= ST_ACTIVE;
                    ST_ACTIVE: if (~s_wstb)          wr_st <= ST_IDLE;
                    default:                         wr_st <= ST_IDLE;
                endcase
                case (rd_st)
                    ST_IDLE:   if (s_rstb & ~p_rstb) rd_st <= ST_ACTIVE;
                    ST_ACTIVE: if (~s_rstb)          rd_st <= ST_IDLE;
                    default:                         rd_st <= ST_IDLE;
                endcase
            end
        end
    end

    // h_* hold the sample from the last strobe-high cycle, i.e. the latest valid read data.
    assign wr_end = (wr_st == ST_ACTIVE) & ~s_wstb;
    assign rd_end = (rd_st == ST_ACTIVE) & ~s_rstb;
    assign in_win = (h_addr >= ADR_LO) && (h_addr <= ADR_HI);
    assign push   = (wr_end | rd_end) & s_en & in_win;
    assign pop    = ev_valid & ev_ready;
    assign drop   = push & fifo_full & ~pop;

`ifdef IO_CAPTURE_TIMESTAMP_EN
    logic [IO_TS_W-1:0] ts_cnt;

    always_ff @(posedge clk_cpu) begin
        if (reset_cpu) ts_cnt <= '0;
        else           ts_cnt <= ts_cnt + IO_TS_W'(1);
    end

    assign ev_in   = '{dir: rd_end ? DIR_RD : DIR_WR, addr: h_addr, data: h_data, tstamp: ts_cnt};
    assign ev_time = ev_head.tstamp;
`else
    assign ev_in   = '{dir: rd_end ? DIR_RD : DIR_WR, addr: h_addr, data: h_data};
`endif

    monitor_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_cpu   (clk_cpu),
        .reset_cpu (reset_cpu),
        .wr_en     (push),
        .wr_data   (ev_in),
        .rd_en     (pop),
        .rd_data   (ev_head),
        .level     (ev_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_dir   = ev_head.dir;
    assign ev_addr  = ev_head.addr;
    assign ev_data  = ev_head.data;

    // A clear coinciding with a drop wins.
    always_ff @(posedge clk_cpu) begin
        if (reset_cpu || ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
